// File: rtl/pe_pkg.sv
// pe_pkg: shared opcode fields, opcode constants, PE latency and issue FSM states
package pe_pkg;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 25;
  localparam int FUNC_HI = 24;
  localparam int FUNC_LO = 20;
  localparam logic [6:0] OP_ARITH = 7'b0000001;
  localparam logic [6:0] OP_FPU = 7'b0000010;
  localparam logic [6:0] OP_COMP = 7'b0010000;
  localparam int PE_LAT = 2;
  typedef enum logic {ISSUE, WAIT_CHAIN} issue_state_t;
endpackage

// File: rtl/pe_issue_fifo.sv
// pe_issue_fifo: circular instruction buffer with wrap-bit pointers and occupancy count
module pe_issue_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];
  // pointer update; flush discards everything including a same-cycle push
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= push ? wptr + (AW + 1)'(1) : wptr;
      rptr <= pop ? rptr + (AW + 1)'(1) : rptr;
    end
  // storage write, no reset needed since entries are only read when occupied
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/pe_issue_queue.sv
// pe_issue_queue: in-order issue stage for the PE core; define PE_ISSUE_CHAIN_EN for result chaining into op3
module pe_issue_queue #(
  parameter int DEPTH = 8,
  parameter int DATA_W = 32,
  parameter int PE_LAT = pe_pkg::PE_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_opcode,
  input  logic [DATA_W-1:0]       in_op1,
  input  logic [DATA_W-1:0]       in_op2,
  input  logic [DATA_W-1:0]       in_op3,
  input  logic                    in_chain,
  output logic                    pe_valid,
  output logic [31:0]             pe_opcode,
  output logic [DATA_W-1:0]       pe_op1,
  output logic [DATA_W-1:0]       pe_op2,
  output logic [DATA_W-1:0]       pe_op3,
  input  logic [DATA_W-1:0]       pe_result,
  input  logic                    pe_result_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy
);
  import pe_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef PE_ISSUE_CHAIN_EN
  localparam int EW = 33 + 3 * DATA_W;
`else
  localparam int EW = 32 + 3 * DATA_W;
`endif
  logic push, pop, head_chain, in_flight;
  logic [EW-1:0] wdata, rdata;
  logic [31:0] h_opcode;
  logic [DATA_W-1:0] h_op1, h_op2, h_op3, op3_src;
  issue_state_t state, state_nx;
  assign in_ready = (count < CW'(DEPTH)) & !rst;
  assign push = in_valid & in_ready & !flush;
  assign busy = (count != '0) | in_flight;
`ifdef PE_ISSUE_CHAIN_EN
  logic [PE_LAT-1:0] sh;
  logic [DATA_W-1:0] last_result;
  assign wdata = {in_chain, in_opcode, in_op1, in_op2, in_op3};
  assign {head_chain, h_opcode, h_op1, h_op2, h_op3} = rdata;
  assign in_flight = pe_valid | (|sh);
  assign op3_src = head_chain ? last_result : h_op3;
  // issued-valid history and latest PE result; an issue clears the result so a silent predecessor yields 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      last_result <= '0;
    end else begin
      sh <= PE_LAT'({sh, pe_valid});
      last_result <= pop ? '0 : pe_result_valid ? pe_result : last_result;
    end
`else
  logic unused_chain;
  assign wdata = {in_opcode, in_op1, in_op2, in_op3};
  assign {h_opcode, h_op1, h_op2, h_op3} = rdata;
  assign head_chain = 1'b0;
  assign in_flight = pe_valid;
  assign op3_src = h_op3;
  assign unused_chain = ^{in_chain, pe_result, pe_result_valid, PE_LAT[0]};
`endif
  pe_issue_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
    .wdata(wdata), .rdata(rdata), .count(count)
  );
  // issue decision: a chained head stalls while any earlier op is still in the PE
  always_comb begin
    pop = !flush & (count != '0) & !(head_chain & in_flight);
    state_nx = (flush | pop) ? ISSUE : ((count != '0) & head_chain & in_flight) ? WAIT_CHAIN : state;
  end
  // FSM state and registered PE-facing outputs, zeroed when not issuing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ISSUE;
      pe_valid <= 1'b0;
      pe_opcode <= '0;
      pe_op1 <= '0;
      pe_op2 <= '0;
      pe_op3 <= '0;
    end else begin
      state <= state_nx;
      pe_valid <= pop;
      pe_opcode <= pop ? h_opcode : '0;
      pe_op1 <= pop ? h_op1 : '0;
      pe_op2 <= pop ? h_op2 : '0;
      pe_op3 <= pop ? op3_src : '0;
    end
endmodule
